// File: rtl/rv32_register_file_if.sv
// Register-file access bundle between the core datapath and the register file.
// The core (master) supplies decoded indices, format flags and write data;
// the register file (slave) returns the two operand values combinationally.
interface rv32_register_file_if;
   logic [4:0]  rs1_idx;     // source register 1 index, instruction[19:15]
   logic [4:0]  rs2_idx;     // source register 2 index, instruction[24:20]
   logic [4:0]  rd_idx;      // destination index, instruction[11:7]
   logic        need_rs1;    // instruction format reads rs1
   logic        need_rs2;    // instruction format reads rs2
   logic        need_rd;     // instruction format writes rd
   logic [31:0] rs1;         // operand 1 read data
   logic [31:0] rs2;         // operand 2 read data
   logic [31:0] rd;          // write data for rd
   logic        wr_request;  // level-sensitive retire-time write request

   modport master (
      output rs1_idx, rs2_idx, rd_idx,
      output need_rs1, need_rs2, need_rd,
      output rd, wr_request,
      input  rs1, rs2
   );

   modport slave (
      input  rs1_idx, rs2_idx, rd_idx,
      input  need_rs1, need_rs2, need_rd,
      input  rd, wr_request,
      output rs1, rs2
   );
endinterface

// File: rtl/rv32_register_file.sv
// RV32I integer register file: 31 writable 32-bit registers plus x0 tied to zero.
// Two combinational read ports, one synchronous write port. Reset clears every
// register asynchronously, so the storage is built from flops rather than RAM.
// Reads see the stored value only; there is no write-to-read bypass, so a read
// of the register being written returns the old value until the clock edge.
module rv32_register_file (
   input  logic                       i_clock,
   input  logic                       i_reset,
   rv32_register_file_if.slave        bus
);

   // Qualified write: a request only commits when the format writes rd and
   // the destination is not x0.
   logic        wr_en;
   logic [31:0] wr_sel;
   logic [31:0] reg_view [32];
   logic [31:0] rs1_next;
   logic [31:0] rs2_next;

   assign wr_en = bus.wr_request && bus.need_rd && (bus.rd_idx != 5'd0);

   // x0 is hardwired to zero and never stored.
   assign reg_view[0] = 32'h0000_0000;
   assign wr_sel[0]   = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < 32; gi = gi + 1) begin : g_reg
         logic [31:0] value_reg;

         // One-hot write select for this register.
         assign wr_sel[gi] = wr_en && (bus.rd_idx == gi[4:0]);

         // Storage for register gi: async clear, load on selected write.
         always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
               value_reg <= 32'h0000_0000;
            end else if (wr_sel[gi]) begin
               value_reg <= bus.rd;
            end
         end

         assign reg_view[gi] = value_reg;
      end
   endgenerate

   // Read port 1: masked by the format flag, x0 and reset.
   always_comb begin
      rs1_next = 32'h0000_0000;
      if (!i_reset && bus.need_rs1 && (bus.rs1_idx != 5'd0)) begin
         rs1_next = reg_view[bus.rs1_idx];
      end
   end

   // Read port 2: same masking, independent of port 1 and the write index.
   always_comb begin
      rs2_next = 32'h0000_0000;
      if (!i_reset && bus.need_rs2 && (bus.rs2_idx != 5'd0)) begin
         rs2_next = reg_view[bus.rs2_idx];
      end
   end

   assign bus.rs1 = rs1_next;
   assign bus.rs2 = rs2_next;

endmodule

// File: tb/tb_rv32_register_file.sv
// Directed self-checking bench for rv32_register_file.
// Inputs change on the falling clock edge; outputs are checked mid-cycle.
module tb_rv32_register_file;

   logic i_clock;
   logic i_reset;
   int   total;
   int   bad;

   rv32_register_file_if rf_if ();

   rv32_register_file dut (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .bus     (rf_if.slave)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one write for a single rising edge, then drop the request.
   task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
      @(negedge i_clock);
      rf_if.rd_idx     = idx;
      rf_if.rd         = val;
      rf_if.need_rd    = 1'b1;
      rf_if.wr_request = 1'b1;
      @(negedge i_clock);
      rf_if.wr_request = 1'b0;
      rf_if.need_rd    = 1'b0;
   endtask

   // Read an index on both ports with both need flags high.
   task automatic read_both(input logic [4:0] idx, input string tag, input logic [31:0] exp);
      rf_if.need_rs1 = 1'b1;
      rf_if.need_rs2 = 1'b1;
      rf_if.rs1_idx  = idx;
      rf_if.rs2_idx  = idx;
      #1;
      check($sformatf("%s_rs1_x%0d", tag, idx), rf_if.rs1, exp);
      check($sformatf("%s_rs2_x%0d", tag, idx), rf_if.rs2, exp);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      i_reset          = 1'b0;
      rf_if.rs1_idx    = 5'd0;
      rf_if.rs2_idx    = 5'd0;
      rf_if.rd_idx     = 5'd0;
      rf_if.need_rs1   = 1'b0;
      rf_if.need_rs2   = 1'b0;
      rf_if.need_rd    = 1'b0;
      rf_if.rd         = 32'h0;
      rf_if.wr_request = 1'b0;

      // 1. Asynchronous reset pulse between clock edges.
      #1 i_reset = 1'b1;
      #2 i_reset = 1'b0;
      for (int i = 1; i < 32; i++) read_both(i[4:0], "reset", 32'h0);
      $display("txn reset: all indices read zero on both ports");

      // 2. Basic write then combinational read on both ports.
      write_reg(5'd5, 32'hDEADBEEF);
      read_both(5'd5, "basic", 32'hDEADBEEF);
      $display("txn write x5=deadbeef, read back on rs1/rs2");

      // 3. x0 writes are discarded and x0 reads zero.
      write_reg(5'd0, 32'hFFFFFFFF);
      read_both(5'd0, "x0", 32'h0);
      rf_if.rs2_idx = 5'd5;
      #1 check("x0_no_alias_x5", rf_if.rs2, 32'hDEADBEEF);
      $display("txn write x0=ffffffff discarded");

      // 4a. Request without need_rd does not write.
      @(negedge i_clock);
      rf_if.rd_idx = 5'd7; rf_if.rd = 32'h12345678;
      rf_if.need_rd = 1'b0; rf_if.wr_request = 1'b1;
      @(negedge i_clock);
      rf_if.wr_request = 1'b0;
      read_both(5'd7, "gate_needrd", 32'h0);
      // 4b. need_rd without request does not write.
      @(negedge i_clock);
      rf_if.need_rd = 1'b1; rf_if.wr_request = 1'b0;
      @(negedge i_clock);
      rf_if.need_rd = 1'b0;
      read_both(5'd7, "gate_wrreq", 32'h0);
      $display("txn gated writes to x7 held at zero");

      // 5. Read-during-write returns old value until the edge.
      write_reg(5'd3, 32'h11111111);
      @(negedge i_clock);
      rf_if.need_rs1 = 1'b1; rf_if.rs1_idx = 5'd3;
      rf_if.need_rs2 = 1'b0; rf_if.rs2_idx = 5'd3;
      rf_if.rd_idx = 5'd3; rf_if.rd = 32'h22222222;
      rf_if.need_rd = 1'b1; rf_if.wr_request = 1'b1;
      #1;
      check("rdw_before_edge", rf_if.rs1, 32'h11111111);
      check("rdw_rs2_masked", rf_if.rs2, 32'h0);
      @(posedge i_clock); #1;
      check("rdw_after_edge", rf_if.rs1, 32'h22222222);
      check("rdw_rs2_still_masked", rf_if.rs2, 32'h0);
      // Held request with stable inputs is idempotent.
      @(posedge i_clock); #1;
      check("rdw_held_request", rf_if.rs1, 32'h22222222);
      @(negedge i_clock);
      rf_if.wr_request = 1'b0; rf_if.need_rd = 1'b0;
      rf_if.need_rs1 = 1'b0;
      #1 check("rs1_need_masked", rf_if.rs1, 32'h0);
      // Independent ports on different registers.
      rf_if.need_rs1 = 1'b1; rf_if.need_rs2 = 1'b1;
      rf_if.rs1_idx = 5'd5; rf_if.rs2_idx = 5'd3;
      #1;
      check("indep_rs1_x5", rf_if.rs1, 32'hDEADBEEF);
      check("indep_rs2_x3", rf_if.rs2, 32'h22222222);
      $display("txn read-during-write x3 11111111->22222222");

      // 6. Fill x1..x31 with distinct values, then reset during a write.
      for (int i = 1; i < 32; i++) write_reg(i[4:0], i * 32'h01010101);
      for (int i = 1; i < 32; i++) read_both(i[4:0], "fill", i * 32'h01010101);
      $display("txn fill x1..x31 with n*01010101");
      @(negedge i_clock);
      rf_if.rd_idx = 5'd9; rf_if.rd = 32'hAAAA5555;
      rf_if.need_rd = 1'b1; rf_if.wr_request = 1'b1;
      #1 i_reset = 1'b1;
      #1;
      read_both(5'd9, "rst_immediate", 32'h0);
      @(posedge i_clock); #1;
      i_reset = 1'b0;
      rf_if.wr_request = 1'b0; rf_if.need_rd = 1'b0;
      for (int i = 1; i < 32; i++) read_both(i[4:0], "rst_mid", 32'h0);
      $display("txn reset during write to x9: all cleared, write lost");

      // Register file is usable again after reset.
      write_reg(5'd31, 32'hCAFEF00D);
      read_both(5'd31, "post_reset", 32'hCAFEF00D);
      $display("txn post-reset write x31=cafef00d");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv32_register_file.md
Name: rv32_register_file

Overview:
- RV32I integer register file: 32 x 32-bit general-purpose registers, x0 hardwired to zero.
- Sits inside the multi-cycle CPU core.
- Provides two asynchronous (combinational) read ports indexed by the decoded rs1/rs2 fields.
- Provides one synchronous write port indexed by rd, committed when the core asserts its retire-time write request.

Parameters:
None. Data width 32 and register count 32 are fixed.

Ports:
- i_clock  input  1  core clock; all writes on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_rs1_idx  input  5  source register 1 index (instruction[19:15]).
- i_rs2_idx  input  5  source register 2 index (instruction[24:20]).
- i_rd_idx  input  5  destination register index (instruction[11:7]).
- i_need_rs1  input  1  current instruction format uses rs1 (B/I/R/S).
- i_need_rs2  input  1  current instruction format uses rs2 (B/R/S).
- i_need_rd  input  1  current instruction format writes rd (I/J/R/U).
- o_rs1  output  32  read data, port 1.
- o_rs2  output  32  read data, port 2.
- i_rd  input  32  write data for rd.
- i_wr_request  input  1  write enable; level-sensitive, sampled on rising clock.

Behaviour:
- Reset: i_reset high asynchronously clears all 32 registers to 32'h0000_0000, immediately and independent of clock. While reset is held:
  - no writes occur;
  - o_rs1 and o_rs2 read 0.
- Reads are purely combinational, zero latency:
  - o_rs1 = (i_need_rs1 && i_rs1_idx != 0) ? reg[i_rs1_idx] : 0.
  - o_rs2 = (i_need_rs2 && i_rs2_idx != 0) ? reg[i_rs2_idx] : 0.
  - A need flag low forces the corresponding output to 0.
- Write: on each rising i_clock edge with i_reset low, if i_wr_request && i_need_rd && i_rd_idx != 0, then reg[i_rd_idx] <= i_rd. Otherwise the array holds its contents.
- Write request is level-sensitive. Holding it high for several cycles with stable inputs rewrites the same value (idempotent). The core normally pulses it for one cycle after retire.
- x0: writes to index 0 are discarded. Reads of index 0 always return 0.
- Read-during-write, same index, same cycle: the read returns the OLD value until the edge. The new value is visible combinationally after the edge. No write-to-read bypass.
- Both read ports may address the same register simultaneously and return identical data. Ports are independent of each other and of the write index.
- Reset asserted mid-operation, including while i_wr_request is high: reset wins. The register is cleared and the pending write is lost.
- No other state, no handshake, no stall outputs.

Test Plan:
1. Reset check: pulse i_reset asynchronously, no clock edge. Then read every index 1..31 on both ports with need flags high -> all outputs read 0.
2. Basic write/read:
   - Write 32'hDEADBEEF to x5 (need_rd=1, wr_request=1, one clock).
   - Set rs1_idx=5, rs2_idx=5 -> both outputs read DEADBEEF in the same cycle the index changes (combinational).
3. x0 protection: write 32'hFFFFFFFF to rd_idx=0 -> o_rs1 with rs1_idx=0 stays 0.
4. Write gating:
   - i_wr_request=1, i_need_rd=0, write 32'h12345678 to x7 -> x7 unchanged (0).
   - i_need_rd=1, i_wr_request=0 -> x7 unchanged (0).
5. Read-during-write:
   - x3 holds 32'h11111111; drive write of 32'h22222222 to x3 with rs1_idx=3.
   - Before the edge o_rs1 = 11111111; after the edge o_rs1 = 22222222.
   - Need-flag masking: with i_need_rs2=0 and rs2_idx=3, o_rs2 = 0.
6. Reset mid-write: fill x1..x31 with distinct values (x_n = n*32'h01010101). Assert i_reset while wr_request is high -> all registers read 0 immediately, and no write lands on the next edge while reset is held.
